cache_miss_ctrl: RTL and testbench
==================================

Name: cache_miss_ctrl

Overview:
- Miss handler between the 2-way, 8-set cache controller (8-bit data, 2-bit tag, 3-bit index) and the 32x8 ramlpm backing RAM.
- On a cache miss it accepts one request, writes back a dirty victim, and fetches the missing byte from RAM (read miss) or takes the store data directly (write-allocate miss).
- Returns a one-cycle fill pulse that the cache uses to refill the victim way.
- Also keeps saturating miss and write-back statistics.

Parameters:
- ADDR_W, 5, RAM address width ({tag, index}).
- INDEX_W, 3, set index width; tag width = ADDR_W - INDEX_W.
- DATA_W, 8, data byte width.
- RAM_LAT, 1, RAM read latency in cycles from the address-sampling edge to valid ram_q (legal range 1..3).
- CNT_W, 16, statistics counter width.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  miss request from the cache
- req_ready  out  1  controller idle and able to accept a request
- req_addr  in  ADDR_W  missing address {tag[4:3], index[2:0]}
- req_write  in  1  1 = store miss, 0 = load miss
- req_wdata  in  DATA_W  store data (used only when req_write=1)
- victim_dirty  in  1  selected victim way has V=1 and D=1
- victim_tag  in  ADDR_W-INDEX_W  tag of the victim line
- victim_data  in  DATA_W  data of the victim line
- ram_address  out  ADDR_W  RAM address
- ram_data  out  DATA_W  RAM write data
- ram_wren  out  1  RAM write enable (registered)
- ram_q  in  DATA_W  RAM read data
- fill_valid  out  1  one-cycle refill strobe
- fill_index  out  INDEX_W  set to refill
- fill_tag  out  ADDR_W-INDEX_W  new tag
- fill_data  out  DATA_W  new data
- fill_dirty  out  1  D bit for the refilled line
- miss_count  out  CNT_W  accepted requests, saturating
- wb_count  out  CNT_W  write-backs performed, saturating

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. All outputs are 0 except req_ready=1. Counters clear.
- Reset mid-operation: return to IDLE immediately and drop ram_wren in the same cycle. The pending request is discarded with no fill pulse; a partially issued write-back is not retried.
- States: IDLE, WB, RD, WAIT, FILL. req_ready is 1 only in IDLE.
- IDLE, on req_valid=1:
  - Capture req_addr, req_write, req_wdata and the victim_* inputs.
  - Increment miss_count.
  - Next state: victim_dirty ? WB : (req_write ? FILL : RD).
- WB (1 cycle):
  - ram_wren=1, ram_address={victim_tag, index}, ram_data=victim_data.
  - Increment wb_count.
  - Next state: req_write ? FILL : RD.
- RD (1 cycle): ram_wren=0, ram_address=captured req_addr. Next state: WAIT.
- WAIT:
  - Lasts exactly RAM_LAT cycles, counted by a down-counter.
  - On the last WAIT cycle, ram_q is registered into fill_data.
  - Next state: FILL.
- FILL (1 cycle):
  - fill_valid=1, fill_index=index, fill_tag=tag.
  - fill_data = read data, or req_wdata for a store miss.
  - fill_dirty = req_write.
  - Next state: IDLE.
- Fill outputs hold their values outside FILL; only fill_valid qualifies them. The cache cannot back-pressure a fill.
- Latency in cycles, from the accept edge to fill_valid high:
  - clean read miss: 2 + RAM_LAT
  - dirty read miss: 3 + RAM_LAT
  - clean store miss: 1
  - dirty store miss: 2
- Victim address equal to the miss address (same tag): the write-back is still performed and the read follows it, so RAM returns the written-back value.
- ram_address holds its last value in IDLE. ram_wren is never high outside WB.
- Counters saturate at all-ones; no wrap-around.
- Inputs other than req_valid are don't-care while req_ready=0.

Decomposition:
- cache_pkg holds:
  - the field widths (TAG_W=2, INDEX_W=3, DATA_W=8)
  - the cache line bit positions (V=12, D=11, LRU=10, tag 9:8, data 7:0)
  - the state enum
  - address slice helper functions for tag and index
- One natural sub-module, sat_counter (width-parameterised, increment enable, saturate at max, async active-low clear), instantiated for miss_count and wb_count.

Test Plan:
- Reset, then clean load miss: preload RAM[0x0B]=0x5A; req_addr=0x0B, req_write=0, victim_dirty=0.
  - Expect: fill_valid high exactly 3 cycles after accept (RAM_LAT=1), fill_index=3, fill_tag=1, fill_data=0x5A, fill_dirty=0, miss_count=1, wb_count=0.
- Dirty load miss: req_addr=0x05; victim_tag=2, victim_data=0xC3, victim_dirty=1.
  - Expect: one cycle with ram_wren=1, ram_address=0x15, ram_data=0xC3; then a read of 0x05.
  - fill_valid 4 cycles after accept; wb_count increments by 1.
- Store miss with dirty victim: req_write=1, req_wdata=0x77, req_addr=0x1F, victim_tag=0, victim_dirty=1.
  - Expect: write-back to 0x07, then fill_valid 2 cycles after accept with fill_data=0x77, fill_dirty=1, and no RAM read issued.
- Back-to-back requests with req_valid held high: the second request is accepted only on the cycle after FILL (req_ready=0 throughout). Same-tag victim case: a read after write-back returns victim_data.
- Reset pulled low during WAIT, 1 cycle:
  - Expect: ram_wren=0 and req_ready=1 immediately; no fill_valid pulse.
  - A new request after release completes normally.
- Counter saturation: force miss_count to 0xFFFE, issue 3 misses -> count stays at 0xFFFF.

Source files
------------

// File: rtl/cache_pkg.sv
// Purpose: shared widths, cache line bit layout, miss-handler state encoding and address helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cache_pkg;

    localparam int CACHE_TAG_W   = 2;
    localparam int CACHE_INDEX_W = 3;
    localparam int CACHE_DATA_W  = 8;
    localparam int CACHE_ADDR_W  = CACHE_TAG_W + CACHE_INDEX_W;

    // Cache line layout: {V, D, LRU, tag[1:0], data[7:0]}
    localparam int LINE_V_BIT   = 12;
    localparam int LINE_D_BIT   = 11;
    localparam int LINE_LRU_BIT = 10;
    localparam int LINE_TAG_HI  = 9;
    localparam int LINE_TAG_LO  = 8;
    localparam int LINE_DATA_HI = 7;
    localparam int LINE_DATA_LO = 0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WB   = 3'd1,
        ST_RD   = 3'd2,
        ST_WAIT = 3'd3,
        ST_FILL = 3'd4
    } miss_state_t;

    function automatic logic [CACHE_TAG_W-1:0] addr_tag(input logic [CACHE_ADDR_W-1:0] addr);
        return addr[CACHE_ADDR_W-1:CACHE_INDEX_W];
    endfunction

    function automatic logic [CACHE_INDEX_W-1:0] addr_index(input logic [CACHE_ADDR_W-1:0] addr);
        return addr[CACHE_INDEX_W-1:0];
    endfunction

endpackage

// File: rtl/cache_miss_ctrl_if.sv
// Purpose: bundles the miss request, victim info, backing-RAM port and refill strobe.
// Latency: n/a (wiring only).
// Backpressure: req_ready gates requests; the fill strobe cannot be back-pressured.
// Ports: master = cache + RAM side, slave = miss controller.
interface cache_miss_ctrl_if #(
    parameter int ADDR_W  = 5,
    parameter int INDEX_W = 3,
    parameter int DATA_W  = 8
);
    localparam int TAG_W = ADDR_W - INDEX_W;

    logic               req_valid;
    logic               req_ready;
    logic [ADDR_W-1:0]  req_addr;
    logic               req_write;
    logic [DATA_W-1:0]  req_wdata;
    logic               victim_dirty;
    logic [TAG_W-1:0]   victim_tag;
    logic [DATA_W-1:0]  victim_data;
    logic [ADDR_W-1:0]  ram_address;
    logic [DATA_W-1:0]  ram_data;
    logic               ram_wren;
    logic [DATA_W-1:0]  ram_q;
    logic               fill_valid;
    logic [INDEX_W-1:0] fill_index;
    logic [TAG_W-1:0]   fill_tag;
    logic [DATA_W-1:0]  fill_data;
    logic               fill_dirty;

    modport master (
        output req_valid, req_addr, req_write, req_wdata,
        output victim_dirty, victim_tag, victim_data, ram_q,
        input  req_ready, ram_address, ram_data, ram_wren,
        input  fill_valid, fill_index, fill_tag, fill_data, fill_dirty
    );

    modport slave (
        input  req_valid, req_addr, req_write, req_wdata,
        input  victim_dirty, victim_tag, victim_data, ram_q,
        output req_ready, ram_address, ram_data, ram_wren,
        output fill_valid, fill_index, fill_tag, fill_data, fill_dirty
    );

endinterface

// File: rtl/sat_counter.sv
// Purpose: up-counter that sticks at all-ones instead of wrapping.
// Latency: count_o reflects an increment one cycle after inc_i.
// Backpressure: none; increments beyond all-ones are dropped.
// Ports: clk_i, rst_ni (async active-low clear), inc_i, count_o.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + WIDTH'(1);
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/cache_miss_ctrl.sv
// Purpose: cache miss handler -- dirty victim write-back, RAM fetch or store-allocate, one-cycle refill.
// Latency: accept->fill 2+RAM_LAT clean load, 3+RAM_LAT dirty load, 1 clean store, 2 dirty store.
// Backpressure: req_ready only in IDLE; fill strobe is fire-and-forget.
// Ports: clock, reset (async active-low), bus (slave modport), miss_count / wb_count statistics.
module cache_miss_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W  = CACHE_ADDR_W,
    parameter int INDEX_W = CACHE_INDEX_W,
    parameter int DATA_W  = CACHE_DATA_W,
    parameter int RAM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    cache_miss_ctrl_if.slave bus,
    output logic [CNT_W-1:0] miss_count,
    output logic [CNT_W-1:0] wb_count
);

    localparam int         TAG_W     = ADDR_W - INDEX_W;
    localparam logic [1:0] WAIT_INIT = 2'(RAM_LAT - 1);

    miss_state_t        state_q, state_d;
    logic [1:0]         wait_q, wait_d;

    // Request captured at accept
    logic [ADDR_W-1:0]  addr_q;
    logic               write_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [TAG_W-1:0]   vtag_q;
    logic [DATA_W-1:0]  vdata_q;

    // Registered outputs
    logic [ADDR_W-1:0]  ram_address_q, ram_address_d;
    logic [DATA_W-1:0]  ram_data_q, ram_data_d;
    logic               ram_wren_q, ram_wren_d;
    logic [INDEX_W-1:0] fill_index_q, fill_index_d;
    logic [TAG_W-1:0]   fill_tag_q, fill_tag_d;
    logic [DATA_W-1:0]  fill_data_q, fill_data_d;
    logic               fill_dirty_q, fill_dirty_d;

    logic               accept;
    logic               in_idle;
    logic [ADDR_W-1:0]  cur_addr;
    logic               cur_write;
    logic [DATA_W-1:0]  cur_wdata;
    logic [TAG_W-1:0]   cur_vtag;
    logic [DATA_W-1:0]  cur_vdata;

    assign in_idle = (state_q == ST_IDLE);
    assign accept  = in_idle && bus.req_valid;

    // On the accept edge the request is still on the inputs, afterwards it lives in
    // the capture registers; the next-value logic reads whichever is current.
    assign cur_addr  = in_idle ? bus.req_addr    : addr_q;
    assign cur_write = in_idle ? bus.req_write   : write_q;
    assign cur_wdata = in_idle ? bus.req_wdata   : wdata_q;
    assign cur_vtag  = in_idle ? bus.victim_tag  : vtag_q;
    assign cur_vdata = in_idle ? bus.victim_data : vdata_q;

    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        ram_address_d = ram_address_q;
        ram_data_d    = ram_data_q;
        fill_index_d  = fill_index_q;
        fill_tag_d    = fill_tag_q;
        fill_data_d   = fill_data_q;
        fill_dirty_d  = fill_dirty_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (bus.victim_dirty) state_d = ST_WB;
                    else if (bus.req_write) state_d = ST_FILL;
                    else state_d = ST_RD;
                end
            end
            ST_WB:   state_d = write_q ? ST_FILL : ST_RD;
            ST_RD: begin
                state_d = ST_WAIT;
                wait_d  = WAIT_INIT;
            end
            ST_WAIT: begin
                if (wait_q == 2'd0) state_d = ST_FILL;
                else wait_d = wait_q - 2'd1;
            end
            ST_FILL: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // RAM port values are set up for the state being entered, so ram_wren is a
        // flop that is high exactly while the FSM sits in WB.
        ram_wren_d = (state_d == ST_WB);
        if (state_d == ST_WB) begin
            ram_address_d = {cur_vtag, cur_addr[INDEX_W-1:0]};
            ram_data_d    = cur_vdata;
        end else if (state_d == ST_RD) begin
            ram_address_d = cur_addr;
        end

        // Fill fields only move when FILL is entered and hold otherwise.
        if (state_d == ST_FILL) begin
            fill_index_d = cur_addr[INDEX_W-1:0];
            fill_tag_d   = cur_addr[ADDR_W-1:INDEX_W];
            fill_data_d  = (state_q == ST_WAIT) ? bus.ram_q : cur_wdata;
            fill_dirty_d = cur_write;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            wait_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q        <= '0;
            write_q       <= 1'b0;
            wdata_q       <= '0;
            vtag_q        <= '0;
            vdata_q       <= '0;
            ram_address_q <= '0;
            ram_data_q    <= '0;
            ram_wren_q    <= 1'b0;
            fill_index_q  <= '0;
            fill_tag_q    <= '0;
            fill_data_q   <= '0;
            fill_dirty_q  <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= bus.req_addr;
                write_q <= bus.req_write;
                wdata_q <= bus.req_wdata;
                vtag_q  <= bus.victim_tag;
                vdata_q <= bus.victim_data;
            end
            ram_address_q <= ram_address_d;
            ram_data_q    <= ram_data_d;
            ram_wren_q    <= ram_wren_d;
            fill_index_q  <= fill_index_d;
            fill_tag_q    <= fill_tag_d;
            fill_data_q   <= fill_data_d;
            fill_dirty_q  <= fill_dirty_d;
        end
    end

    assign bus.req_ready   = in_idle;
    assign bus.fill_valid  = (state_q == ST_FILL);
    assign bus.ram_address = ram_address_q;
    assign bus.ram_data    = ram_data_q;
    assign bus.ram_wren    = ram_wren_q;
    assign bus.fill_index  = fill_index_q;
    assign bus.fill_tag    = fill_tag_q;
    assign bus.fill_data   = fill_data_q;
    assign bus.fill_dirty  = fill_dirty_q;

    sat_counter #(.WIDTH(CNT_W)) u_miss_cnt (
        .clk_i   (clock),
        .rst_ni  (reset),
        .inc_i   (accept),
        .count_o (miss_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_wb_cnt (
        .clk_i   (clock),
        .rst_ni  (reset),
        .inc_i   (state_q == ST_WB),
        .count_o (wb_count)
    );

endmodule

// File: tb/tb_cache_miss_ctrl.sv
module tb_cache_miss_ctrl;

    localparam int LAT = 1;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    cache_miss_ctrl_if #(.ADDR_W(5), .INDEX_W(3), .DATA_W(8)) bus ();
    cache_miss_ctrl_if #(.ADDR_W(5), .INDEX_W(3), .DATA_W(8)) bus2 ();

    logic [15:0] miss_count, wb_count;
    logic [1:0]  miss_count2, wb_count2;

    cache_miss_ctrl #(.RAM_LAT(LAT), .CNT_W(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .miss_count (miss_count),
        .wb_count   (wb_count)
    );

    // Narrow-counter twin fed the same inputs, used to observe saturation.
    cache_miss_ctrl #(.RAM_LAT(LAT), .CNT_W(2)) dut2 (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus2),
        .miss_count (miss_count2),
        .wb_count   (wb_count2)
    );

    assign bus2.req_valid    = bus.req_valid;
    assign bus2.req_addr     = bus.req_addr;
    assign bus2.req_write    = bus.req_write;
    assign bus2.req_wdata    = bus.req_wdata;
    assign bus2.victim_dirty = bus.victim_dirty;
    assign bus2.victim_tag   = bus.victim_tag;
    assign bus2.victim_data  = bus.victim_data;
    assign bus2.ram_q        = bus.ram_q;

    // Backing RAM: 32x8, one-cycle registered read
    logic [7:0] mem [32];
    logic [7:0] rd_q;
    logic       pl_we;
    logic [4:0] pl_addr;
    logic [7:0] pl_dat;

    always @(posedge clock) begin
        if (pl_we) mem[pl_addr] <= pl_dat;
        else if (bus.ram_wren) mem[bus.ram_address] <= bus.ram_data;
        rd_q <= mem[bus.ram_address];
    end
    assign bus.ram_q = rd_q;

    // Reference model state
    logic [7:0] ref_mem [32];
    int         exp_miss, exp_wb;
    logic [4:0] exp_last_addr;
    int         errors, checks;

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic check_counts(input string name);
        checks++;
        if (miss_count !== 16'(exp_miss)) begin
            errors++; $display("FAIL %s miss_count: got %0d want %0d", name, miss_count, exp_miss);
        end
        checks++;
        if (wb_count !== 16'(exp_wb)) begin
            errors++; $display("FAIL %s wb_count: got %0d want %0d", name, wb_count, exp_wb);
        end
        checks++;
        if (miss_count2 !== 2'(sat3(exp_miss))) begin
            errors++; $display("FAIL %s miss_count_sat: got %0d want %0d", name, miss_count2, sat3(exp_miss));
        end
        checks++;
        if (wb_count2 !== 2'(sat3(exp_wb))) begin
            errors++; $display("FAIL %s wb_count_sat: got %0d want %0d", name, wb_count2, sat3(exp_wb));
        end
    endtask

    task automatic preload();
        logic [7:0] v;
        for (int i = 0; i < 32; i++) begin
            @(negedge clock);
            v = (i == 11) ? 8'h5A : 8'($urandom);
            pl_we = 1'b1; pl_addr = 5'(i); pl_dat = v;
            ref_mem[i] = v;
        end
        @(negedge clock);
        pl_we = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        checks++;
        if (bus.req_ready !== 1'b1 || bus.ram_wren !== 1'b0 || bus.fill_valid !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl: ready=%b wren=%b fill=%b want 1 0 0",
                               bus.req_ready, bus.ram_wren, bus.fill_valid);
        end
        checks++;
        if (bus.ram_address !== 5'd0 || bus.ram_data !== 8'd0) begin
            errors++; $display("FAIL reset_ram: addr=%0h data=%0h want 0 0", bus.ram_address, bus.ram_data);
        end
        checks++;
        if ({bus.fill_index, bus.fill_tag, bus.fill_data, bus.fill_dirty} !== 14'd0) begin
            errors++; $display("FAIL reset_fill: idx=%0h tag=%0h data=%0h dirty=%b want all 0",
                               bus.fill_index, bus.fill_tag, bus.fill_data, bus.fill_dirty);
        end
        check_counts("reset");
        reset = 1'b1;
    endtask

    task automatic run_miss(input string name, input logic [4:0] addr, input logic wr,
                            input logic [7:0] wd, input logic vd, input logic [1:0] vt,
                            input logic [7:0] vdat);
        int         exp_lat, fill_at, wcnt;
        logic       early_ready, ready_at_fill;
        logic [4:0] waddr, wb_addr;
        logic [7:0] wdat, exp_data;
        logic [2:0] f_idx;
        logic [1:0] f_tag;
        logic [7:0] f_data;
        logic       f_dirty;

        @(negedge clock);
        bus.req_addr = addr; bus.req_write = wr; bus.req_wdata = wd;
        bus.victim_dirty = vd; bus.victim_tag = vt; bus.victim_data = vdat;
        bus.req_valid = 1'b1;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL %s ready_idle: got %b want 1", name, bus.req_ready);
        end

        exp_miss++;
        wb_addr = {vt, addr[2:0]};
        if (vd) begin
            exp_wb++;
            ref_mem[wb_addr] = vdat;
        end
        exp_data = wr ? wd : ref_mem[addr];
        exp_lat  = wr ? (vd ? 2 : 1) : (vd ? 3 + LAT : 2 + LAT);
        if (!wr) exp_last_addr = addr;
        else if (vd) exp_last_addr = wb_addr;

        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        bus.req_addr = 5'($urandom); bus.req_write = 1'($urandom); bus.req_wdata = 8'($urandom);
        bus.victim_dirty = 1'($urandom); bus.victim_tag = 2'($urandom); bus.victim_data = 8'($urandom);

        fill_at = 0; wcnt = 0; early_ready = 1'b0; ready_at_fill = 1'b0;
        waddr = '0; wdat = '0; f_idx = '0; f_tag = '0; f_data = '0; f_dirty = 1'b0;
        for (int k = 1; k <= 12 && fill_at == 0; k++) begin
            if (bus.ram_wren) begin
                wcnt++; waddr = bus.ram_address; wdat = bus.ram_data;
            end
            if (bus.fill_valid) begin
                fill_at = k; ready_at_fill = bus.req_ready;
                f_idx = bus.fill_index; f_tag = bus.fill_tag;
                f_data = bus.fill_data; f_dirty = bus.fill_dirty;
            end else begin
                if (bus.req_ready) early_ready = 1'b1;
                @(posedge clock); #1;
            end
        end

        checks++;
        if (fill_at != exp_lat) begin
            errors++; $display("FAIL %s latency: got %0d want %0d (0 = no fill)", name, fill_at, exp_lat);
        end
        checks++;
        if (f_idx !== addr[2:0] || f_tag !== addr[4:3]) begin
            errors++; $display("FAIL %s fill_addr: idx=%0h tag=%0h want %0h %0h", name, f_idx, f_tag, addr[2:0], addr[4:3]);
        end
        checks++;
        if (f_data !== exp_data || f_dirty !== wr) begin
            errors++; $display("FAIL %s fill_data: data=%0h dirty=%b want %0h %b", name, f_data, f_dirty, exp_data, wr);
        end
        checks++;
        if (early_ready !== 1'b0 || ready_at_fill !== 1'b0) begin
            errors++; $display("FAIL %s busy_ready: got %b/%b want 0/0", name, early_ready, ready_at_fill);
        end
        checks++;
        if (wcnt != (vd ? 1 : 0)) begin
            errors++; $display("FAIL %s wb_cycles: got %0d want %0d", name, wcnt, vd ? 1 : 0);
        end
        if (vd) begin
            checks++;
            if (waddr !== wb_addr || wdat !== vdat) begin
                errors++; $display("FAIL %s wb_write: addr=%0h data=%0h want %0h %0h", name, waddr, wdat, wb_addr, vdat);
            end
        end

        @(posedge clock); #1;
        checks++;
        if (bus.fill_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.ram_wren !== 1'b0) begin
            errors++; $display("FAIL %s after_fill: fill=%b ready=%b wren=%b want 0 1 0",
                               name, bus.fill_valid, bus.req_ready, bus.ram_wren);
        end
        checks++;
        if (bus.fill_data !== exp_data || bus.fill_tag !== addr[4:3]) begin
            errors++; $display("FAIL %s fill_hold: data=%0h tag=%0h want %0h %0h", name, bus.fill_data, bus.fill_tag, exp_data, addr[4:3]);
        end
        checks++;
        if (bus.ram_address !== exp_last_addr) begin
            errors++; $display("FAIL %s ram_addr_hold: got %0h want %0h", name, bus.ram_address, exp_last_addr);
        end
        check_counts(name);
    endtask

    task automatic test_back_to_back();
        logic [4:0] a1, a2;
        logic [7:0] x, e1;
        int         rdy_at, f1_at, f2_at, nf, nrdy;
        logic [7:0] f1_data, f2_data;

        a1 = 5'($urandom);
        a2 = 5'($urandom);
        x  = 8'($urandom);
        @(negedge clock);
        bus.req_addr = a1; bus.req_write = 1'b0; bus.req_wdata = 8'($urandom);
        bus.victim_dirty = 1'b0; bus.victim_tag = 2'($urandom); bus.victim_data = 8'($urandom);
        bus.req_valid = 1'b1;

        exp_miss += 2;
        exp_wb++;
        e1 = ref_mem[a1];
        ref_mem[a2] = x;
        exp_last_addr = a2;

        @(posedge clock); #1;
        // Second request: same-tag dirty victim, so the read returns the written-back byte
        bus.req_addr = a2; bus.victim_dirty = 1'b1; bus.victim_tag = a2[4:3]; bus.victim_data = x;

        rdy_at = 0; f1_at = 0; f2_at = 0; nf = 0; nrdy = 0; f1_data = '0; f2_data = '0;
        for (int s = 1; s <= 14; s++) begin
            if (bus.req_ready && nf < 2) begin
                nrdy++;
                if (rdy_at == 0) rdy_at = s;
            end
            if (bus.fill_valid) begin
                if (nf == 0) begin f1_at = s; f1_data = bus.fill_data; end
                else begin f2_at = s; f2_data = bus.fill_data; end
                nf++;
            end
            @(posedge clock); #1;
            if (s == rdy_at) bus.req_valid = 1'b0;
        end

        checks++;
        if (f1_at != 2 + LAT || f1_data !== e1) begin
            errors++; $display("FAIL b2b_first: at=%0d data=%0h want %0d %0h", f1_at, f1_data, 2 + LAT, e1);
        end
        checks++;
        if (rdy_at != 3 + LAT || nrdy != 1) begin
            errors++; $display("FAIL b2b_ready: at=%0d count=%0d want %0d 1", rdy_at, nrdy, 3 + LAT);
        end
        checks++;
        if (f2_at != (3 + LAT) + (3 + LAT) || f2_data !== x) begin
            errors++; $display("FAIL b2b_second: at=%0d data=%0h want %0d %0h", f2_at, f2_data, 6 + 2 * LAT, x);
        end
        check_counts("b2b");
    endtask

    task automatic test_reset_mid(input string name, input int at_sample, input logic vd);
        logic saw_fill;
        @(negedge clock);
        bus.req_addr = 5'($urandom); bus.req_write = 1'b0; bus.req_wdata = 8'($urandom);
        bus.victim_dirty = vd; bus.victim_tag = 2'($urandom); bus.victim_data = 8'($urandom);
        bus.req_valid = 1'b1;
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        for (int k = 1; k < at_sample; k++) begin
            @(posedge clock); #1;
        end
        checks++;
        if (bus.ram_wren !== vd || bus.req_ready !== 1'b0) begin
            errors++; $display("FAIL %s pre_reset: wren=%b ready=%b want %b 0", name, bus.ram_wren, bus.req_ready, vd);
        end
        reset = 1'b0;
        #1;
        exp_miss = 0; exp_wb = 0; exp_last_addr = 5'd0;
        checks++;
        if (bus.ram_wren !== 1'b0 || bus.req_ready !== 1'b1 || bus.fill_valid !== 1'b0) begin
            errors++; $display("FAIL %s in_reset: wren=%b ready=%b fill=%b want 0 1 0",
                               name, bus.ram_wren, bus.req_ready, bus.fill_valid);
        end
        check_counts(name);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        saw_fill = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clock); #1;
            if (bus.fill_valid) saw_fill = 1'b1;
        end
        checks++;
        if (saw_fill !== 1'b0) begin
            errors++; $display("FAIL %s no_fill: got %b want 0", name, saw_fill);
        end
    endtask

    task automatic test_random(input int n);
        logic [4:0] a;
        for (int i = 0; i < n; i++) begin
            a = 5'($urandom);
            run_miss("rand", a, 1'($urandom), 8'($urandom), 1'($urandom),
                     ($urandom_range(0, 3) == 0) ? a[4:3] : 2'($urandom), 8'($urandom));
        end
    endtask

    initial begin
        errors = 0; checks = 0;
        exp_miss = 0; exp_wb = 0; exp_last_addr = 5'd0;
        pl_we = 1'b0; pl_addr = '0; pl_dat = '0;
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_write = 1'b0; bus.req_wdata = '0;
        bus.victim_dirty = 1'b0; bus.victim_tag = '0; bus.victim_data = '0;
        reset = 1'b0;

        preload();
        test_reset();
        run_miss("clean_load", 5'h0B, 1'b0, 8'h00, 1'b0, 2'd3, 8'h11);
        run_miss("dirty_load", 5'h05, 1'b0, 8'h00, 1'b1, 2'd2, 8'hC3);
        run_miss("dirty_store", 5'h1F, 1'b1, 8'h77, 1'b1, 2'd0, 8'h3C);
        run_miss("clean_store", 5'h12, 1'b1, 8'hA5, 1'b0, 2'd1, 8'h99);
        test_back_to_back();
        test_reset_mid("reset_in_wb", 1, 1'b1);
        run_miss("after_reset_wb", 5'h0E, 1'b0, 8'h00, 1'b1, 2'd3, 8'h6D);
        test_reset_mid("reset_in_wait", 2, 1'b0);
        run_miss("after_reset_wait", 5'h1A, 1'b0, 8'h00, 1'b0, 2'd0, 8'h00);
        test_random(24);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
